sqrt_result_buffer: RTL and testbench

- Flow-control shell placed around the pipelined integer square-root core.
- The sqrt pipeline has no backpressure, so this block provides a valid/ready request port upstream and gates issue into the core with a credit counter.
- It captures every root/remainder pair the core emits in a DEPTH-entry FIFO and presents them on a valid/ready result port downstream.
- Results are never dropped, whatever the core's pipeline latency or stage mask.

---
 rtl/sqrt_result_buffer.sv | 111 +++++++++++
 tb/tb_sqrt_result_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_result_buffer.sv
// Credit-gated valid/ready shell around a backpressure-free pipelined sqrt core.
// Every core result lands in a DEPTH-entry FIFO that is drained through a valid/ready port.
module sqrt_result_buffer #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATAWIDTH-1:0]   s_rad,
    output logic                   sq_i_valid,
    output logic [DATAWIDTH-1:0]   sq_rad,
    input  logic                   sq_o_valid,
    input  logic [DATAWIDTH-1:0]   sq_root,
    input  logic [DATAWIDTH-1:0]   sq_rem,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATAWIDTH-1:0]   m_root,
    output logic [DATAWIDTH-1:0]   m_rem,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DATAWIDTH-1:0] root;
        logic [DATAWIDTH-1:0] rem;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          ovf_q, ovf_d;

    logic issue, pop, full, wr_en;

    // s_ready depends only on registered credit state, never on s_valid/m_ready.
    assign s_ready    = (outstanding_q < CW'(DEPTH));
    assign issue      = s_valid & s_ready;
    assign sq_i_valid = issue;
    assign sq_rad     = s_rad;

    assign m_valid = (occ_q != '0);
    assign pop     = m_valid & m_ready;
    assign m_root  = mem_q[rd_ptr_q].root;
    assign m_rem   = mem_q[rd_ptr_q].rem;

    assign full  = (occ_q == CW'(DEPTH));
    assign wr_en = sq_o_valid & (~full | pop);

    assign outstanding = outstanding_q;
    assign ovf         = ovf_q;

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !pop)
            outstanding_d = outstanding_q + CW'(1);
        else if (pop && !issue)
            outstanding_d = outstanding_q - CW'(1);

        occ_d = occ_q;
        if (wr_en && !pop)
            occ_d = occ_q + CW'(1);
        else if (pop && !wr_en)
            occ_d = occ_q - CW'(1);

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

        ovf_d = ovf_q | (sq_o_valid & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            occ_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ovf_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            occ_q         <= occ_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ovf_q         <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q].root <= sq_root;
            mem_q[wr_ptr_q].rem  <= sq_rem;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occ_q <= outstanding_q);
            assert (outstanding_q <= CW'(DEPTH));
            assert (!(pop && !issue && outstanding_q == '0));
            assert (PW'(wr_ptr_q - rd_ptr_q) == occ_q[PW-1:0]);
        end
    end

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// Scoreboard bench for sqrt_result_buffer with a behavioural 3-stage sqrt core attached.
module tb_sqrt_result_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LAT   = 3;

    typedef struct packed {
        logic [DW-1:0] root;
        logic [DW-1:0] rem;
    } res_t;

    logic          clk = 0;
    logic          rst;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_rad;
    logic          sq_i_valid, sq_o_valid;
    logic [DW-1:0] sq_rad, sq_root, sq_rem;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_root, m_rem;
    logic [CW-1:0] outstanding;
    logic          ovf;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    sqrt_result_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_rad(s_rad),
        .sq_i_valid(sq_i_valid), .sq_rad(sq_rad),
        .sq_o_valid(sq_o_valid), .sq_root(sq_root), .sq_rem(sq_rem),
        .m_valid(m_valid), .m_ready(m_ready), .m_root(m_root), .m_rem(m_rem),
        .outstanding(outstanding), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] iroot(input logic [DW-1:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] irem(input logic [DW-1:0] x);
        int r = int'(iroot(x));
        int d = int'(x) - r * r;
        return d[DW-1:0];
    endfunction

    // Behavioural sqrt core: fixed latency, no backpressure, reset with the shell.
    logic          cv [LAT];
    logic [DW-1:0] cr [LAT];
    logic [DW-1:0] cm [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) cv[i] <= 1'b0;
        end else begin
            cv[0] <= sq_i_valid;
            cr[0] <= iroot(sq_rad);
            cm[0] <= irem(sq_rad);
            for (int i = 1; i < LAT; i++) begin
                cv[i] <= cv[i-1];
                cr[i] <= cr[i-1];
                cm[i] <= cm[i-1];
            end
        end
    end
    assign sq_o_valid = cv[LAT-1];
    assign sq_root    = cr[LAT-1];
    assign sq_rem     = cm[LAT-1];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    logic          hold = 0;
    logic [DW-1:0] h_root, h_rem;
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_root", int'(m_root), int'(h_root));
                chk("hold_rem", int'(m_rem), int'(h_rem));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got root=%0d rem=%0d expected none", m_root, m_rem);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_root", int'(m_root), int'(e.root));
                    chk("m_rem", int'(m_rem), int'(e.rem));
                end
            end
            hold   = m_valid && !m_ready;
            h_root = m_root;
            h_rem  = m_rem;
        end
    end

    // One cycle of stimulus; records the expected result if the request is accepted.
    task automatic step(input bit v, input logic [DW-1:0] rad, input logic [DW-1:0] er,
                        input logic [DW-1:0] em, input bit mr, output bit acc);
        s_valid = v;
        s_rad   = rad;
        m_ready = mr;
        @(negedge clk);
        acc = v && s_ready;
        if (acc) exp_q.push_back('{root: er, rem: em});
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input bit mr, output bit acc);
        logic [DW-1:0] r = DW'($urandom_range(0, 255));
        step(1'b1, r, iroot(r), irem(r), mr, acc);
    endtask

    task automatic drain(input string name);
        bit acc;
        int n = 0;
        while ((exp_q.size() != 0 || outstanding != 0) && n < 200) begin
            step(1'b0, '0, '0, '0, 1'b1, acc);
            n++;
        end
        chk({name, "_drained"}, int'(exp_q.size() == 0 && outstanding == 0), 1);
    endtask

    initial begin
        bit acc;
        int n, got;
        rst = 1; s_valid = 0; s_rad = '0; m_ready = 0;
        step(1'b0, '0, '0, '0, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b0, acc);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 0;

        // Single op: m_valid must follow sq_o_valid by exactly one cycle.
        step(1'b1, 8'd200, 8'd14, 8'd4, 1'b1, acc);
        chk("single_acc", int'(acc), 1);
        s_valid = 0;
        n = 0;
        @(negedge clk);
        while (!sq_o_valid && n < 20) begin @(negedge clk); n++; end
        chk("single_core_valid", int'(sq_o_valid), 1);
        chk("single_m_valid_pre", int'(m_valid), 0);
        @(negedge clk);
        chk("single_m_valid_next", int'(m_valid), 1);
        @(posedge clk); #1;
        chk("single_outstanding", int'(outstanding), 0);
        drain("single");

        // Back-to-back with m_ready held high.
        step(1'b1, 8'd0,   8'd0,  8'd0,  1'b1, acc); chk("b2b_acc0", int'(acc), 1);
        step(1'b1, 8'd1,   8'd1,  8'd0,  1'b1, acc); chk("b2b_acc1", int'(acc), 1);
        step(1'b1, 8'd255, 8'd15, 8'd30, 1'b1, acc); chk("b2b_acc2", int'(acc), 1);
        step(1'b1, 8'd144, 8'd12, 8'd0,  1'b1, acc); chk("b2b_acc3", int'(acc), 1);
        drain("b2b");

        // Backpressure: credits cap acceptance at DEPTH.
        got = 0;
        for (int i = 0; i < 10; i++) begin
            step_rand(1'b0, acc);
            if (acc) got++;
        end
        chk("bp_accepted", got, DEPTH);
        chk("bp_outstanding", int'(outstanding), DEPTH);
        chk("bp_s_ready", int'(s_ready), 0);
        chk("bp_ovf", int'(ovf), 0);
        step_rand(1'b1, acc);
        chk("bp_no_issue_on_pop", int'(acc), 0);
        step_rand(1'b0, acc);
        chk("bp_issue_after_pop", int'(acc), 1);
        chk("bp_outstanding_refill", int'(outstanding), DEPTH);
        step(1'b0, '0, '0, '0, 1'b1, acc);
        chk("bp_outstanding_3", int'(outstanding), 3);
        step_rand(1'b1, acc);
        chk("bp_simul_acc", int'(acc), 1);
        chk("bp_simul_outstanding", int'(outstanding), 3);
        drain("bp");

        // Random stream with ~50% downstream ready exercises pointer wrap.
        got = 0; n = 0;
        while (got < 20 && n < 1000) begin
            step_rand(1'($urandom_range(0, 1)), acc);
            if (acc) got++;
            n++;
        end
        chk("rand_issued", got, 20);
        drain("rand");
        chk("rand_ovf", int'(ovf), 0);

        // Reset with 3 results buffered and 1 still inside the core.
        for (int i = 0; i < 4; i++) begin
            step_rand(1'b0, acc);
            chk("mid_acc", int'(acc), 1);
        end
        step(1'b0, '0, '0, '0, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b0, acc);
        rst = 1;
        exp_q.delete();
        step(1'b0, '0, '0, '0, 1'b0, acc);
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_outstanding", int'(outstanding), 0);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        rst = 0;
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, '0, 1'b1, acc);
        chk("mid_no_stale", int'(m_valid), 0);
        step(1'b1, 8'd81, 8'd9, 8'd0, 1'b1, acc);
        chk("mid_acc81", int'(acc), 1);
        drain("mid");

        chk("final_ovf", int'(ovf), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
